piso_tx_arbiter: RTL and testbench

Round-robin transmit scheduler that shares one parallel-in/serial-out shifter among N parallel requesters. It grants one requester at a time, loads that requester's W-bit word into the shared shifter and sequences W MSB-first shift cycles. It also marks the frame with valid, first and last strobes and the source index. It sits between the lab's parallel word producers and a single serial output line.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_tx_arbiter_if.sv | 25 ++
 rtl/piso_shift.sv | 32 +++
 rtl/piso_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_piso_tx_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmit arbiter.
package piso_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

    localparam int unsigned DefN   = 4;
    localparam int unsigned DefW   = 4;
    localparam int unsigned DefGap = 1;

    // Index/counter width for a range of n values, never below 1 bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_arbiter_if.sv
// Requester-side bus and serial output of the PISO transmit arbiter.
interface piso_tx_arbiter_if #(
    parameter int unsigned N = piso_pkg::DefN,
    parameter int unsigned W = piso_pkg::DefW
);
    logic [N-1:0]                   req;
    logic [N*W-1:0]                 data;
    logic [N-1:0]                   ack;
    logic                           so;
    logic                           so_valid;
    logic                           so_first;
    logic                           so_last;
    logic [piso_pkg::src_w(N)-1:0]  src;
    logic                           busy;

    modport master (
        output req, data,
        input  ack, so, so_valid, so_first, so_last, src, busy
    );

    modport slave (
        input  req, data,
        output ack, so, so_valid, so_first, so_last, src, busy
    );
endinterface

// File: rtl/piso_shift.sv
// W-bit parallel-load, MSB-first shift register; load wins over shift.
module piso_shift #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] pi,
    output logic         so
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = pi;
        end else if (shift) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign so = sr_q[W-1];
endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin scheduler sharing one PISO shifter among N requesters,
// with framing strobes, source index and an optional inter-frame gap.
module piso_tx_arbiter
    import piso_pkg::*;
#(
    parameter int unsigned N   = DefN,
    parameter int unsigned W   = DefW,
    parameter int unsigned GAP = DefGap
) (
    input logic               clk,
    input logic               rst,
    piso_tx_arbiter_if.slave  bus
);
    localparam int unsigned SW      = src_w(N);
    localparam int unsigned CW      = src_w(W);
    localparam int unsigned GW      = src_w(GAP);
    localparam int unsigned GapLast = (GAP > 0) ? GAP - 1 : 0;

    state_t         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [SW-1:0]  src_q, src_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           valid_q, valid_d;
    logic           first_q, first_d;
    logic           last_q, last_d;

    logic           found;
    logic [SW-1:0]  win;
    int unsigned    idx;
    logic [W-1:0]   win_data;
    logic           load, shift, shift_so;

    // Search ptr, ptr+1, ... mod N for the first asserted request.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    assign win_data = bus.data[32'(win)*W +: W];
    assign load     = (state_q == StIdle) && found;
    assign shift    = (state_q == StShift);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        ack_d   = '0;
        valid_d = valid_q;
        first_d = 1'b0;
        last_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StShift;
                    src_d   = win;
                    ack_d   = N'(1) << win;
                    cnt_d   = CW'(W - 1);
                    ptr_d   = SW'((32'(win) + 1) % N);
                    valid_d = 1'b1;
                    first_d = 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    valid_d = 1'b0;
                    if (GAP > 0) begin
                        state_d = StGap;
                        gcnt_d  = GW'(GapLast);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    last_d = (cnt_q == CW'(1));
                end
            end
            StGap: begin
                if (gcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    piso_shift #(
        .W (W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .pi    (win_data),
        .so    (shift_so)
    );

    assign bus.ack      = ack_q;
    assign bus.so       = shift_so & valid_q;
    assign bus.so_valid = valid_q;
    assign bus.so_first = first_q;
    assign bus.so_last  = last_q;
    assign bus.src      = src_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench: one GAP=1 instance for arbitration/framing, one GAP=0 instance.
module tb_piso_tx_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    piso_tx_arbiter_if #(.N(4), .W(4)) a ();
    piso_tx_arbiter_if #(.N(4), .W(4)) b ();

    piso_tx_arbiter #(.N(4), .W(4), .GAP(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    piso_tx_arbiter #(.N(4), .W(4), .GAP(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int          ng;
        int          last_c;
        int          starts[4];
        logic [3:0]  pat;
        logic [3:0]  msb_exp;
        logic [9:0]  vpat;
        logic        seen;

        total = 0;
        bad   = 0;
        rst    = 1'b0;
        a.req  = '1;
        a.data = '0;
        b.req  = '0;
        b.data = '0;

        // Reset with all requests high
        repeat (2) @(negedge clk);
        chk("rst_so", a.so, 0);
        chk("rst_valid", a.so_valid, 0);
        chk("rst_first", a.so_first, 0);
        chk("rst_last", a.so_last, 0);
        chk("rst_ack", a.ack, 0);
        chk("rst_src", a.src, 0);
        chk("rst_busy", a.busy, 0);
        a.req = '0;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", a.busy, 0);
            chk("idle_valid", a.so_valid, 0);
        end

        // Single request from requester 1, word 1011
        a.data = 16'h00B0;
        a.req  = 4'b0010;
        pat    = 4'b1011;
        @(negedge clk);
        chk("one_ack", a.ack, 4'b0010);
        chk("one_src", a.src, 1);
        chk("one_valid1", a.so_valid, 1);
        chk("one_first1", a.so_first, 1);
        chk("one_last1", a.so_last, 0);
        chk("one_so1", a.so, 1);
        a.req = '0;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("one_so", a.so, pat[4-i]);
            chk("one_valid", a.so_valid, 1);
            chk("one_first", a.so_first, 0);
            chk("one_last", a.so_last, (i == 4) ? 1 : 0);
            chk("one_ack_clr", a.ack, 0);
        end
        @(negedge clk);
        chk("one_gap_valid", a.so_valid, 0);
        chk("one_gap_so", a.so, 0);
        chk("one_gap_busy", a.busy, 1);
        @(negedge clk);
        chk("one_idle_busy", a.busy, 0);

        // All four request together right after reset
        rst = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        a.data  = 16'hDC95;
        msb_exp = 4'b1110;
        a.req   = 4'hF;
        ng      = 0;
        last_c  = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (a.ack != '0) begin
                if (ng < 4) begin
                    starts[ng] = c;
                    chk("sim_ack", a.ack, 4'b0001 << ng);
                    chk("sim_src", a.src, ng);
                    chk("sim_msb", a.so, msb_exp[ng]);
                end
                ng++;
                a.req = a.req & ~a.ack;
            end
            if (a.so_last) last_c = c;
        end
        chk("sim_grants", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk("sim_start", starts[i], 1 + 6 * i);
        end
        chk("sim_end", last_c, 22);

        // Fairness between requesters 0 and 2
        ng    = 0;
        a.req = 4'b0101;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (a.ack != '0) begin
                if (ng < 4) chk("fair_ack", a.ack, (ng % 2 == 1) ? 4'b0100 : 4'b0001);
                ng++;
            end
            a.req = (ng >= 4) ? 4'b0000 : (4'b0101 & ~a.ack);
        end
        chk("fair_grants", ng, 4);

        // Reset after two bits of a frame from requester 3
        a.data = 16'hB000;
        a.req  = 4'b1000;
        @(negedge clk);
        chk("mrst_ack", a.ack, 4'b1000);
        chk("mrst_src", a.src, 3);
        chk("mrst_so1", a.so, 1);
        a.req = '0;
        @(negedge clk);
        chk("mrst_so2", a.so, 0);
        chk("mrst_valid2", a.so_valid, 1);
        rst = 1'b0;
        #1;
        chk("mrst_valid_now", a.so_valid, 0);
        chk("mrst_so_now", a.so, 0);
        chk("mrst_busy_now", a.busy, 0);
        chk("mrst_src_now", a.src, 0);
        chk("mrst_last_now", a.so_last, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mrst_last_hold", a.so_last, 0);
            chk("mrst_ack_hold", a.ack, 0);
        end
        a.data = 16'h700A;
        a.req  = 4'b1001;
        rst    = 1'b1;
        @(negedge clk);
        chk("mrst_reacq_ack", a.ack, 4'b0001);
        chk("mrst_reacq_src", a.src, 0);
        chk("mrst_reacq_so", a.so, 1);
        a.req = 4'b1000;
        seen  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a.ack != '0 && !seen) begin
                seen = 1'b1;
                chk("mrst_next_ack", a.ack, 4'b1000);
                chk("mrst_next_cyc", c, 6);
                a.req = '0;
            end
        end
        chk("mrst_next_seen", seen, 1);
        repeat (6) @(negedge clk);
        chk("mrst_done_busy", a.busy, 0);

        // GAP=0 instance: zero word frames back to back
        b.data = 16'h0000;
        b.req  = 4'b0001;
        vpat   = 10'b1111011110;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("g0_valid", b.so_valid, vpat[10-c]);
            chk("g0_busy", b.busy, vpat[10-c]);
            chk("g0_so", b.so, 0);
            chk("g0_last", b.so_last, (c == 4 || c == 9) ? 1 : 0);
            chk("g0_first", b.so_first, (c == 1 || c == 6) ? 1 : 0);
            b.req = (c >= 6) ? 4'b0000 : (4'b0001 & ~b.ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
